// File: rtl/mad_arbiter_pkg.sv
// Shared sizes and the in-flight tag type for the two-requester MAD arbiter.
package mad_arbiter_pkg;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 4;
  localparam int OP_W    = 8;
  localparam int RES_W   = 16;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;
endpackage

// File: rtl/mad_rsp_fifo.sv
// Per-requester result FIFO: head shown combinationally (0 when empty), simultaneous
// write and pop both take effect, pops on empty are ignored.
module mad_rsp_fifo
  import mad_arbiter_pkg::*;
#(
  parameter int DEPTH = mad_arbiter_pkg::DEPTH,
  parameter int W     = RES_W,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic [CW-1:0] o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_rd = i_rd_en && (r_count != '0);
  // A write into a full FIFO is only accepted when the head leaves in the same cycle.
  assign w_wr = i_wr_en && ((r_count != CW'(DEPTH)) || w_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= next_ptr(r_wptr);
      if (w_rd) r_rptr <= next_ptr(r_rptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wr_data;
  end

  assign o_rd_data = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign o_count   = r_count;
endmodule

// File: rtl/mad_arbiter.sv
// Round-robin share of one MAD pipeline between two requesters; results return LATENCY
// edges after issue into per-requester FIFOs, and a requester stalls at DEPTH outstanding.
module mad_arbiter
  import mad_arbiter_pkg::*;
#(
  parameter int LATENCY = mad_arbiter_pkg::LATENCY,
  parameter int DEPTH   = mad_arbiter_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req0_valid,
  input  logic [OP_W-1:0]  i_req0_a,
  input  logic [OP_W-1:0]  i_req0_b,
  input  logic [OP_W-1:0]  i_req0_c,
  input  logic             i_req1_valid,
  input  logic [OP_W-1:0]  i_req1_a,
  input  logic [OP_W-1:0]  i_req1_b,
  input  logic [OP_W-1:0]  i_req1_c,
  output logic             o_req0_ready,
  output logic             o_req1_ready,
  output logic [OP_W-1:0]  o_mad_a,
  output logic [OP_W-1:0]  o_mad_b,
  output logic [OP_W-1:0]  o_mad_c,
  input  logic [RES_W-1:0] i_mad_answer,
  output logic             o_rsp0_valid,
  output logic [RES_W-1:0] o_rsp0_data,
  input  logic             i_rsp0_ready,
  output logic             o_rsp1_valid,
  output logic [RES_W-1:0] o_rsp1_data,
  input  logic             i_rsp1_ready,
  output logic             o_busy
);
  localparam int CW = $clog2(DEPTH + 1);

  tag_t             r_tag [LATENCY];
  logic [CW-1:0]    r_out0;
  logic [CW-1:0]    r_out1;
  logic             r_last1;
  logic             w_elig0, w_elig1;
  logic             w_gnt0, w_gnt1, w_issue;
  logic             w_pop0, w_pop1;
  logic             w_wr0, w_wr1;
  logic             w_tag_any;
  logic [CW-1:0]    w_cnt0, w_cnt1;
  logic [RES_W-1:0] w_head0, w_head1;

  function automatic logic [CW-1:0] upd(input logic [CW-1:0] cnt, input logic inc,
                                        input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + CW'(1);
      2'b01:   return cnt - CW'(1);
      default: return cnt;
    endcase
  endfunction

  assign w_elig0 = i_req0_valid && (r_out0 < CW'(DEPTH));
  assign w_elig1 = i_req1_valid && (r_out1 < CW'(DEPTH));
  // r_last1 means requester 1 won last, so requester 0 takes the next tie.
  assign w_gnt0  = !reset && w_elig0 && (!w_elig1 || r_last1);
  assign w_gnt1  = !reset && w_elig1 && !w_gnt0;
  assign w_issue = w_gnt0 || w_gnt1;

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;
  assign o_mad_a = w_gnt0 ? i_req0_a : (w_gnt1 ? i_req1_a : '0);
  assign o_mad_b = w_gnt0 ? i_req0_b : (w_gnt1 ? i_req1_b : '0);
  assign o_mad_c = w_gnt0 ? i_req0_c : (w_gnt1 ? i_req1_c : '0);

  assign w_pop0 = (w_cnt0 != '0) && i_rsp0_ready;
  assign w_pop1 = (w_cnt1 != '0) && i_rsp1_ready;
  assign w_wr0  = r_tag[LATENCY-1].vld && !r_tag[LATENCY-1].id;
  assign w_wr1  = r_tag[LATENCY-1].vld &&  r_tag[LATENCY-1].id;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) r_tag[i] <= '0;
      r_out0  <= '0;
      r_out1  <= '0;
      r_last1 <= 1'b1;
    end else begin
      r_tag[0] <= '{vld: w_issue, id: w_gnt1};
      for (int i = 1; i < LATENCY; i++) r_tag[i] <= r_tag[i-1];
      r_out0 <= upd(r_out0, w_gnt0, w_pop0);
      r_out1 <= upd(r_out1, w_gnt1, w_pop1);
      if (w_gnt0)      r_last1 <= 1'b0;
      else if (w_gnt1) r_last1 <= 1'b1;
    end
  end

  always_comb begin
    w_tag_any = 1'b0;
    for (int i = 0; i < LATENCY; i++) w_tag_any = w_tag_any | r_tag[i].vld;
  end

  mad_rsp_fifo #(.DEPTH(DEPTH), .W(RES_W), .CW(CW)) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr0),
    .i_wr_data (i_mad_answer),
    .i_rd_en   (w_pop0),
    .o_rd_data (w_head0),
    .o_count   (w_cnt0)
  );

  mad_rsp_fifo #(.DEPTH(DEPTH), .W(RES_W), .CW(CW)) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr1),
    .i_wr_data (i_mad_answer),
    .i_rd_en   (w_pop1),
    .o_rd_data (w_head1),
    .o_count   (w_cnt1)
  );

  assign o_rsp0_valid = !reset && (w_cnt0 != '0);
  assign o_rsp1_valid = !reset && (w_cnt1 != '0);
  assign o_rsp0_data  = reset ? '0 : w_head0;
  assign o_rsp1_data  = reset ? '0 : w_head1;
  assign o_busy       = !reset && (w_tag_any || (w_cnt0 != '0) || (w_cnt1 != '0));
endmodule

// File: tb/tb_mad_arbiter.sv
// Directed bench for mad_arbiter with a behavioural MAD pipeline and a per-requester scoreboard.
module tb_mad_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req0_valid, i_req1_valid;
  logic [7:0]  i_req0_a, i_req0_b, i_req0_c;
  logic [7:0]  i_req1_a, i_req1_b, i_req1_c;
  logic        o_req0_ready, o_req1_ready;
  logic [7:0]  o_mad_a, o_mad_b, o_mad_c;
  logic [15:0] i_mad_answer;
  logic        o_rsp0_valid, o_rsp1_valid;
  logic [15:0] o_rsp0_data, o_rsp1_data;
  logic        i_rsp0_ready, i_rsp1_ready;
  logic        o_busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_pop0   = 0;
  int n_pop1   = 0;
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];
  logic [15:0] mad_pipe [LAT];

  mad_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req0_valid(i_req0_valid), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_c(i_req0_c),
    .i_req1_valid(i_req1_valid), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_c(i_req1_c),
    .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
    .o_mad_a(o_mad_a), .o_mad_b(o_mad_b), .o_mad_c(o_mad_c),
    .i_mad_answer(i_mad_answer),
    .o_rsp0_valid(o_rsp0_valid), .o_rsp0_data(o_rsp0_data), .i_rsp0_ready(i_rsp0_ready),
    .o_rsp1_valid(o_rsp1_valid), .o_rsp1_data(o_rsp1_data), .i_rsp1_ready(i_rsp1_ready),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mad_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    logic [7:0] s;
    s = a + b;
    return 16'(s) * 16'(c);
  endfunction

  // External MAD pipeline: operands captured at edge t, answer sampled by the DUT at t+LAT.
  always @(posedge clk) begin
    mad_pipe[0] <= mad_fn(o_mad_a, o_mad_b, o_mad_c);
    for (int i = 1; i < LAT; i++) mad_pipe[i] <= mad_pipe[i-1];
  end
  assign i_mad_answer = mad_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on transfer, pop and compare on response handshake.
  always @(negedge clk) begin
    if (reset) begin
      exp0.delete();
      exp1.delete();
    end else begin
      if (i_req0_valid && o_req0_ready) begin
        exp0.push_back(mad_fn(i_req0_a, i_req0_b, i_req0_c));
        chk("mad_a_req0", o_mad_a, i_req0_a);
      end
      if (i_req1_valid && o_req1_ready) begin
        exp1.push_back(mad_fn(i_req1_a, i_req1_b, i_req1_c));
        chk("mad_c_req1", o_mad_c, i_req1_c);
      end
      if (o_rsp0_valid && i_rsp0_ready) begin
        chk("rsp0_expected", exp0.size() != 0, 1);
        if (exp0.size() != 0) chk("rsp0_data", o_rsp0_data, exp0.pop_front());
        n_pop0++;
      end
      if (o_rsp1_valid && i_rsp1_ready) begin
        chk("rsp1_expected", exp1.size() != 0, 1);
        if (exp1.size() != 0) chk("rsp1_data", o_rsp1_data, exp1.pop_front());
        n_pop1++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (!o_busy) idle = 1'b1;
      else step();
    end
    chk("drain_idle", o_busy, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    int   base0, base1;
    logic seen;
    logic g0;

    reset = 1'b1;
    i_req0_valid = 0; i_req1_valid = 0;
    i_req0_a = 0; i_req0_b = 0; i_req0_c = 0;
    i_req1_a = 0; i_req1_b = 0; i_req1_c = 0;
    i_rsp0_ready = 1; i_rsp1_ready = 1;
    repeat (3) step();

    // Outputs held at zero during reset even with a request present.
    i_req0_valid = 1; i_req0_a = 9; i_req0_b = 9; i_req0_c = 9;
    @(negedge clk);
    chk("rst_ready0", o_req0_ready, 0);
    chk("rst_mad_a", o_mad_a, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_rsp0_valid", o_rsp0_valid, 0);
    step();
    reset = 0; i_req0_valid = 0;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_rsp1_valid", o_rsp1_valid, 0);
    step();

    // Single op 3,4,5: result visible exactly LAT edges after the accepting edge.
    i_req0_valid = 1; i_req0_a = 3; i_req0_b = 4; i_req0_c = 5;
    @(negedge clk);
    chk("single_ready0", o_req0_ready, 1);
    chk("single_ready1", o_req1_ready, 0);
    chk("single_mad_b", o_mad_b, 4);
    step();
    i_req0_valid = 0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("single_rsp0_valid", o_rsp0_valid, k == 4);
      if (k == 4) chk("single_rsp0_data", o_rsp0_data, 35);
      else chk("single_busy", o_busy, 1);
      step();
    end
    drain();

    // Add wraps modulo 256 before the multiply.
    i_req0_valid = 1; i_req0_a = 255; i_req0_b = 255; i_req0_c = 255;
    @(negedge clk);
    chk("wrap_ready0", o_req0_ready, 1);
    step();
    i_req0_valid = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (o_rsp0_valid) seen = 1'b1;
      else step();
    end
    chk("wrap_seen", seen, 1);
    chk("wrap_data", o_rsp0_data, 64770);
    step();
    drain();

    // Round robin from a fresh reset: 0,1,0,1,...
    reset = 1; step(); reset = 0;
    base0 = n_pop0; base1 = n_pop1;
    i_req0_valid = 1; i_req0_a = 10; i_req0_b = 1; i_req0_c = 2;
    i_req1_valid = 1; i_req1_a = 20; i_req1_b = 3; i_req1_c = 7;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_ready0", o_req0_ready, (k % 2) == 0);
      chk("rr_ready1", o_req1_ready, (k % 2) == 1);
      g0 = o_req0_ready;
      step();
      if (g0) begin i_req0_a = i_req0_a + 1; i_req0_c = i_req0_c + 3; end
      else    begin i_req1_a = i_req1_a + 5; i_req1_b = i_req1_b + 1; end
    end
    i_req0_valid = 0; i_req1_valid = 0;
    drain();
    chk("rr_pops0", n_pop0 - base0, 4);
    chk("rr_pops1", n_pop1 - base1, 4);

    // Credit limit: no pops on requester 0, so exactly DEPTH accepts.
    i_rsp0_ready = 0;
    i_req0_valid = 1; i_req0_a = 1; i_req0_b = 2; i_req0_c = 3;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      g0 = o_req0_ready;
      if (g0) acc++;
      step();
      if (g0) i_req0_b = i_req0_b + 11;
    end
    chk("bp_accepts", acc, 4);
    @(negedge clk);
    chk("bp_ready0_low", o_req0_ready, 0);
    chk("bp_rsp0_valid", o_rsp0_valid, 1);
    chk("bp_busy", o_busy, 1);
    step();
    i_req1_valid = 1; i_req1_a = 7; i_req1_b = 8; i_req1_c = 9;
    @(negedge clk);
    chk("bp_req1_ready", o_req1_ready, 1);
    chk("bp_req0_blocked", o_req0_ready, 0);
    step();
    i_req1_valid = 0; i_rsp0_ready = 1;
    @(negedge clk);
    chk("bp_pop_cycle_ready0", o_req0_ready, 0);
    step();
    i_rsp0_ready = 0;
    @(negedge clk);
    chk("bp_reaccept", o_req0_ready, 1);
    step();
    i_req0_a = 77;
    @(negedge clk);
    chk("bp_full_again", o_req0_ready, 0);
    step();
    i_req0_valid = 0; i_rsp0_ready = 1;
    drain();

    // Reset two cycles after an issue discards it; first tie afterwards goes to req0.
    i_req0_valid = 1; i_req0_a = 11; i_req0_b = 12; i_req0_c = 13;
    @(negedge clk);
    chk("mid_issue_ready0", o_req0_ready, 1);
    step();
    i_req0_valid = 0;
    step();
    step();
    reset = 1; i_req0_valid = 1; i_req1_valid = 1;
    @(negedge clk);
    chk("mid_rst_ready0", o_req0_ready, 0);
    chk("mid_rst_ready1", o_req1_ready, 0);
    chk("mid_rst_mad_a", o_mad_a, 0);
    chk("mid_rst_busy", o_busy, 0);
    step();
    reset = 0; i_req0_valid = 0; i_req1_valid = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("post_rst_rsp0_valid", o_rsp0_valid, 0);
      chk("post_rst_busy", o_busy, 0);
      step();
    end
    i_req0_valid = 1; i_req1_valid = 1;
    i_req0_a = 2; i_req0_b = 2; i_req0_c = 2;
    i_req1_a = 4; i_req1_b = 4; i_req1_c = 4;
    @(negedge clk);
    chk("post_rst_tie0", o_req0_ready, 1);
    chk("post_rst_tie1", o_req1_ready, 0);
    step();
    i_req0_valid = 0; i_req1_valid = 0;
    drain();

    chk("sb0_empty", exp0.size(), 0);
    chk("sb1_empty", exp1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
